// File: rtl/dmem_arbiter_if.sv
// Bus bundle for dmem_arbiter: pipeline port, DMA port and the DataMemory side.
// The slave view belongs to the arbiter; master is the surrounding requesters plus memory.
interface dmem_arbiter_if #(
    parameter int Width = 32
);
    logic             p_req;
    logic             p_we;
    logic [Width-1:0] p_addr;
    logic [Width-1:0] p_wdata;
    logic [Width-1:0] p_rdata;
    logic             p_ack;
    logic             p_stall;

    logic             d_req;
    logic             d_we;
    logic [Width-1:0] d_addr;
    logic [Width-1:0] d_wdata;
    logic [Width-1:0] d_rdata;
    logic             d_ack;

    logic             mem_re;
    logic             mem_we;
    logic [Width-1:0] mem_addr;
    logic [Width-1:0] mem_wdata;
    logic [Width-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_ack, p_stall,
        input  d_req, d_we, d_addr, d_wdata,
        output d_rdata, d_ack,
        output mem_re, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_ack, p_stall,
        output d_req, d_we, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  mem_re, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the pipeline MEM stage (P) and a DMA port (D),
// sequencing each access IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> RESP with round-robin on ties.
module dmem_arbiter #(
    parameter int Width       = 32,
    parameter int WAIT_CYCLES = 1
) (
    input logic          clk,
    input logic          reset,
    dmem_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    logic [1:0]       state;
    logic             owner;
    logic             rr;
    logic             lat_we;
    logic [Width-1:0] lat_addr;
    logic [Width-1:0] lat_wdata;
    logic [3:0]       cnt;
    logic [Width-1:0] p_rdata_q;
    logic [Width-1:0] d_rdata_q;
    logic             any_req;
    logic             grant_d;
    logic             last_cycle;

    // owner/rr: 0 = pipeline, 1 = DMA; rr only matters when both ports request together
    assign any_req    = bus.p_req | bus.d_req;
    assign grant_d    = bus.d_req & (~bus.p_req | rr);
    assign last_cycle = (state == ST_ACCESS) && (cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner     <= 1'b0;
            rr        <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cnt       <= 4'd0;
            p_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner     <= grant_d;
                        lat_we    <= grant_d ? bus.d_we    : bus.p_we;
                        lat_addr  <= grant_d ? bus.d_addr  : bus.p_addr;
                        lat_wdata <= grant_d ? bus.d_wdata : bus.p_wdata;
                        cnt       <= WAIT_INIT;
                        state     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (cnt == 4'd0) begin
                        if (!lat_we) begin
                            if (owner) d_rdata_q <= bus.mem_rdata;
                            else       p_rdata_q <= bus.mem_rdata;
                        end
                        state <= ST_RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    rr    <= ~owner;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so an aborting reset can never leak a write
    assign bus.mem_re    = (state == ST_ACCESS) & ~lat_we;
    assign bus.mem_we    = last_cycle & lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    assign bus.p_ack   = (state == ST_RESP) & ~owner;
    assign bus.d_ack   = (state == ST_RESP) &  owner;
    assign bus.p_rdata = p_rdata_q;
    assign bus.d_rdata = d_rdata_q;
    assign bus.p_stall = bus.p_req & ~bus.p_ack;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: drivers push expected read data into per-port queues,
// a negedge monitor pops them on every ack; extra instances cover WAIT_CYCLES = 0 and 3.
module tb_dmem_arbiter;
    localparam int          W1  = 1;
    localparam int          W3  = 3;
    localparam int          W0  = 0;
    localparam logic [31:0] KEY = 32'h5A5A5A5A;

    logic clk = 1'b0;
    logic reset;
    logic reset3;
    logic init_mem;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.Width(32)) b1 ();
    dmem_arbiter_if #(.Width(32)) b3 ();
    dmem_arbiter_if #(.Width(32)) b0 ();

    dmem_arbiter #(.Width(32), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .reset(reset),  .bus(b1.slave));
    dmem_arbiter #(.Width(32), .WAIT_CYCLES(W3)) dut3 (.clk(clk), .reset(reset3), .bus(b3.slave));
    dmem_arbiter #(.Width(32), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .reset(reset),  .bus(b0.slave));

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] mem1   [256];
    logic [31:0] shadow [256];
    logic [31:0] p_exp [$];
    logic [31:0] d_exp [$];
    int          ack_log [$];
    logic [31:0] p_last;
    logic [31:0] d_last;
    int          we1_count  = 0;
    int          we3_count  = 0;
    int          ack3_count = 0;

    function automatic logic [31:0] pattern(int i);
        if (i == 16) return 32'hCAFEF00D;
        return 32'hA5000000 ^ (32'(i) * 32'h00010203);
    endfunction

    // Word-indexed DataMemory for the main instance, preloaded during the first reset
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 256; i++) mem1[i] <= pattern(i);
        end else if (b1.mem_we) begin
            mem1[b1.mem_addr[7:0]] <= b1.mem_wdata;
        end
    end

    assign b1.mem_rdata = mem1[b1.mem_addr[7:0]];
    assign b3.mem_rdata = b3.mem_addr ^ KEY;
    assign b0.mem_rdata = b0.mem_addr ^ KEY;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic failNote(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: got event/timeout, expected none", name);
    endtask

    // Issues one access on the main instance; the expectation comes from the shadow memory
    task automatic applyStimulus(input bit port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, output int lat);
        logic [31:0] exp;
        logic        got;
        if (we) begin
            exp = port ? d_last : p_last;
            shadow[addr[7:0]] = wdata;
        end else begin
            exp = shadow[addr[7:0]];
            if (port) d_last = exp;
            else      p_last = exp;
        end
        if (port) d_exp.push_back(exp);
        else      p_exp.push_back(exp);
        @(posedge clk);
        #1;
        if (port) begin
            b1.d_req = 1'b1; b1.d_we = we; b1.d_addr = addr; b1.d_wdata = wdata;
        end else begin
            b1.p_req = 1'b1; b1.p_we = we; b1.p_addr = addr; b1.p_wdata = wdata;
        end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = port ? b1.d_ack : b1.p_ack;
            if (!port) checkOutput(got ? "p_stall_ack" : "p_stall_wait", {31'b0, b1.p_stall}, {31'b0, ~got});
        end
        if (!got) failNote(port ? "d_ack_timeout" : "p_ack_timeout");
        #1;
        if (port) b1.d_req = 1'b0;
        else      b1.p_req = 1'b0;
    endtask

    // Scoreboard monitor for the main instance
    always @(negedge clk) begin
        if (!reset) begin
            if (b1.p_ack) begin
                ack_log.push_back(0);
                if (p_exp.size() == 0) failNote("p_ack_unexpected");
                else checkOutput("p_rdata", b1.p_rdata, p_exp.pop_front());
            end
            if (b1.d_ack) begin
                ack_log.push_back(1);
                if (d_exp.size() == 0) failNote("d_ack_unexpected");
                else checkOutput("d_rdata", b1.d_rdata, d_exp.pop_front());
            end
            if (b1.p_ack && b1.d_ack) failNote("dual_ack");
            if (b1.mem_we && b1.mem_re) failNote("mem_re_we_overlap");
            if (b1.mem_we) we1_count++;
        end
    end

    always @(negedge clk) begin
        if (b3.mem_we) we3_count++;
        if (b3.p_ack || b3.d_ack) ack3_count++;
    end

    initial begin
        int lat;
        int l4;
        int n;
        int re;
        int cyc;
        int last;
        logic got;

        b1.p_req = 0; b1.p_we = 0; b1.p_addr = '0; b1.p_wdata = '0;
        b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
        b3.p_req = 0; b3.p_we = 0; b3.p_addr = '0; b3.p_wdata = '0;
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
        b0.p_req = 0; b0.p_we = 0; b0.p_addr = '0; b0.p_wdata = '0;
        b0.d_req = 0; b0.d_we = 0; b0.d_addr = '0; b0.d_wdata = '0;
        reset = 1'b1; reset3 = 1'b1; init_mem = 1'b1;
        for (int i = 0; i < 256; i++) shadow[i] = pattern(i);
        p_last = '0; d_last = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_p_ack",     {31'b0, b1.p_ack},  32'd0);
        checkOutput("rst_d_ack",     {31'b0, b1.d_ack},  32'd0);
        checkOutput("rst_mem_re",    {31'b0, b1.mem_re}, 32'd0);
        checkOutput("rst_mem_we",    {31'b0, b1.mem_we}, 32'd0);
        checkOutput("rst_p_rdata",   b1.p_rdata,   32'd0);
        checkOutput("rst_d_rdata",   b1.d_rdata,   32'd0);
        checkOutput("rst_mem_addr",  b1.mem_addr,  32'd0);
        checkOutput("rst_mem_wdata", b1.mem_wdata, 32'd0);
        reset = 1'b0; reset3 = 1'b0; init_mem = 1'b0;

        $display("[TB] directed load latency");
        applyStimulus(1'b0, 1'b0, 32'h10, 32'h0, lat);
        checkOutput("t1_latency", lat, W1 + 2);

        $display("[TB] directed store and read back");
        n = we1_count;
        applyStimulus(1'b0, 1'b1, 32'h20, 32'h12345678, lat);
        checkOutput("t2_we_pulses", we1_count - n, 1);
        checkOutput("t2_mem", mem1[32], 32'h12345678);
        applyStimulus(1'b0, 1'b0, 32'h20, 32'h0, lat);

        $display("[TB] round-robin after reset");
        @(posedge clk); #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        p_last = '0; d_last = '0;
        ack_log.delete();
        fork
            begin
                int lp;
                for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 32'($urandom_range(0, 127)), 32'h0, lp);
            end
            begin
                int ld;
                for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 32'($urandom_range(128, 255)), 32'h0, ld);
            end
        join
        checkOutput("t3_grant_count", ack_log.size(), 8);
        for (int i = 0; i < ack_log.size(); i++) checkOutput($sformatf("t3_grant%0d", i), ack_log[i], i % 2);

        $display("[TB] pipeline stalls behind DMA store");
        fork
            begin
                int ld;
                applyStimulus(1'b1, 1'b1, 32'h90, $urandom, ld);
            end
            begin
                @(posedge clk);
                applyStimulus(1'b0, 1'b0, 32'h30, 32'h0, l4);
            end
            begin
                repeat (4) @(posedge clk);
                @(negedge clk);
                checkOutput("t4_stall", {31'b0, b1.p_stall}, 32'd1);
            end
        join
        checkOutput("t4_latency", l4, 2 * W1 + 4);

        $display("[TB] randomized traffic on both ports");
        fork
            begin
                int lp;
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    applyStimulus(1'b0, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 127)), $urandom, lp);
                end
            end
            begin
                int ld;
                repeat (30) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    applyStimulus(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(128, 255)), $urandom, ld);
                end
            end
        join

        $display("[TB] reset during first ACCESS cycle of a store");
        n = we3_count;
        re = ack3_count;
        @(posedge clk);
        #1 b3.p_req = 1'b1; b3.p_we = 1'b1; b3.p_addr = 32'h40; b3.p_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 reset3 = 1'b1;
        @(posedge clk);
        #1 reset3 = 1'b0; b3.p_req = 1'b0; b3.p_we = 1'b0;
        repeat (8) @(posedge clk);
        checkOutput("t5_no_write", we3_count - n, 0);
        checkOutput("t5_no_ack", ack3_count - re, 0);
        #1 b3.p_req = 1'b1; b3.p_addr = 32'h44;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 30) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            got = b3.p_ack;
        end
        if (!got) failNote("t5_ack_timeout");
        checkOutput("t5_latency", lat, W3 + 2);
        checkOutput("t5_rdata", b3.p_rdata, 32'h44 ^ KEY);
        #1 b3.p_req = 1'b0;

        $display("[TB] zero wait states, back-to-back loads");
        @(posedge clk);
        #1 b0.p_req = 1'b1; b0.p_we = 1'b0; b0.p_addr = 32'h100;
        n = 0; re = 0; cyc = 0; last = 0;
        while (n < 6 && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (b0.mem_re) re++;
            if (b0.p_ack) begin
                checkOutput("t6_rdata", b0.p_rdata, b0.p_addr ^ KEY);
                checkOutput(n == 0 ? "t6_first_ack" : "t6_spacing", cyc - last, W0 + 3);
                checkOutput("t6_mem_re_cycles", re, 1);
                re = 0;
                last = cyc;
                n++;
                b0.p_addr = b0.p_addr + 32'd4;
            end
        end
        checkOutput("t6_ack_count", n, 6);
        b0.p_req = 1'b0;

        repeat (3) @(posedge clk);
        checkOutput("p_queue_empty", p_exp.size(), 0);
        checkOutput("d_queue_empty", d_exp.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
